score_controller: RTL and testbench

//   Two-player score keeper for the scoreboard. Takes the single-cycle count_up/count_down

---
 rtl/score_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/score_controller.sv | 215 +++++++++++++++++++++
 tb/tb_score_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared encodings for the two-player score controller.
// Holds the FSM states, request codes, winner codes and the pulse decoder.
package score_pkg;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_WON  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_UP   = 2'b01,
    REQ_DOWN = 2'b10
  } req_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Simultaneous up and down from one player cancel each other.
  function automatic req_t pulse_to_req(input logic up, input logic down);
    req_t r;
    case ({up, down})
      2'b10:   r = REQ_UP;
      2'b01:   r = REQ_DOWN;
      default: r = REQ_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// After any grant, priority moves to the requester that was not granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic       prio_q;
  logic       prio_d;
  logic [1:0] grant_s;

  // Tie-break: prio_q=1 lets requester 1 win a simultaneous request.
  always_comb begin
    case (req)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = prio_q ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  always_comb begin
    if (grant_s[0]) begin
      prio_d = 1'b1;
    end else if (grant_s[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/score_controller.sv
// Two-player score keeper: captures button pulses into pending requests, serialises
// them through a round-robin arbiter, applies saturating updates and tracks the win.
module score_controller
  import score_pkg::*;
#(
  parameter int SCORE_W    = 5,
  parameter int WIN_SCORE  = 11,
  parameter int WIN_MARGIN = 2,
  parameter int BLINK_MS   = 250
) (
  input  logic               clk_1khz,
  input  logic               rst,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic               game_over,
  output logic               update,
  output logic               blink
);

  localparam int                 CNT_W      = $clog2(BLINK_MS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W:0]   WIN_EXT    = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   MARGIN_EXT = (SCORE_W+1)'(WIN_MARGIN);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_MS - 1);

  state_t             state_q, state_d;
  req_t               p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;
  logic               update_q, update_d;
  logic               blink_q, blink_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         grant_s;
  logic               gnt_any_s;
  req_t               gnt_req_s;
  logic [SCORE_W-1:0] own_s, new_own_s, cmt1_s, cmt2_s;
  logic [SCORE_W:0]   ext1_s, ext2_s;
  logic               win1_s, win2_s, clear_s;

  rr_arbiter2 u_arb (
    .clk   (clk_1khz),
    .rst   (rst),
    .req   ({p2_pend_q != REQ_NONE, p1_pend_q != REQ_NONE}),
    .grant (grant_s)
  );

  // A fresh pulse overrides both the held request and a same-cycle grant clear.
  always_comb begin
    p1_pend_d = grant_s[0] ? REQ_NONE : p1_pend_q;
    p2_pend_d = grant_s[1] ? REQ_NONE : p2_pend_q;
    if (pulse_to_req(p1_up, p1_down) != REQ_NONE) begin
      p1_pend_d = pulse_to_req(p1_up, p1_down);
    end else begin
      p1_pend_d = p1_pend_d;
    end
    if (pulse_to_req(p2_up, p2_down) != REQ_NONE) begin
      p2_pend_d = pulse_to_req(p2_up, p2_down);
    end else begin
      p2_pend_d = p2_pend_d;
    end
  end

  // Candidate post-commit scores and the deuce-aware win comparator.
  always_comb begin
    gnt_any_s = grant_s[0] | grant_s[1];
    if (grant_s[0]) begin
      gnt_req_s = p1_pend_q;
      own_s     = score1_q;
    end else if (grant_s[1]) begin
      gnt_req_s = p2_pend_q;
      own_s     = score2_q;
    end else begin
      gnt_req_s = REQ_NONE;
      own_s     = score1_q;
    end
    case (gnt_req_s)
      REQ_UP:   new_own_s = (own_s == SCORE_MAX) ? own_s : own_s + SCORE_W'(1);
      REQ_DOWN: new_own_s = (own_s == SCORE_W'(0)) ? own_s : own_s - SCORE_W'(1);
      default:  new_own_s = own_s;
    endcase
    cmt1_s  = grant_s[0] ? new_own_s : score1_q;
    cmt2_s  = grant_s[1] ? new_own_s : score2_q;
    ext1_s  = {1'b0, cmt1_s};
    ext2_s  = {1'b0, cmt2_s};
    win1_s  = (ext1_s >= WIN_EXT) && (ext1_s >= ext2_s + MARGIN_EXT);
    win2_s  = (ext2_s >= WIN_EXT) && (ext2_s >= ext1_s + MARGIN_EXT);
    clear_s = (gnt_req_s == REQ_DOWN);
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLAY: begin
        if (gnt_any_s && (win1_s || win2_s)) begin
          state_d = ST_WON;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_WON: begin
        if (clear_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_WON;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  // Score, winner and update datapath; in WON only a DOWN grant has an effect.
  always_comb begin
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    update_d = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (gnt_any_s) begin
          score1_d = cmt1_s;
          score2_d = cmt2_s;
          update_d = (new_own_s != own_s);
          if (win1_s) begin
            winner_d = WIN_P1;
          end else if (win2_s) begin
            winner_d = WIN_P2;
          end else begin
            winner_d = WIN_NONE;
          end
        end else begin
          update_d = 1'b0;
        end
      end
      ST_WON: begin
        if (clear_s) begin
          score1_d = SCORE_W'(0);
          score2_d = SCORE_W'(0);
          winner_d = WIN_NONE;
          update_d = 1'b1;
        end else begin
          update_d = 1'b0;
        end
      end
      default: begin
        score1_d = SCORE_W'(0);
        score2_d = SCORE_W'(0);
        winner_d = WIN_NONE;
      end
    endcase
  end

  // Blink runs only while staying in WON; entering or leaving restarts it from 0.
  always_comb begin
    if ((state_q == ST_WON) && (state_d == ST_WON)) begin
      if (cnt_q == BLINK_LAST) begin
        cnt_d   = CNT_W'(0);
        blink_d = ~blink_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        blink_d = blink_q;
      end
    end else begin
      cnt_d   = CNT_W'(0);
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      p1_pend_q <= REQ_NONE;
      p2_pend_q <= REQ_NONE;
      score1_q  <= SCORE_W'(0);
      score2_q  <= SCORE_W'(0);
      winner_q  <= WIN_NONE;
      update_q  <= 1'b0;
      blink_q   <= 1'b0;
      cnt_q     <= CNT_W'(0);
    end else begin
      p1_pend_q <= p1_pend_d;
      p2_pend_q <= p2_pend_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      winner_q  <= winner_d;
      update_q  <= update_d;
      blink_q   <= blink_d;
      cnt_q     <= cnt_d;
    end
  end

  // FSM outputs.
  always_comb begin
    score_p1  = score1_q;
    score_p2  = score2_q;
    winner    = winner_q;
    game_over = (state_q == ST_WON);
    update    = update_q;
    blink     = blink_q;
  end

endmodule

// File: tb/tb_score_controller.sv
// Randomised and directed bench for score_controller, checked every cycle against
// a plain-integer model of the scoring rules plus a few literal expectations.
module tb_score_controller;

  logic       clk_1khz = 1'b0;
  logic       rst      = 1'b1;
  logic       p1_up    = 1'b0;
  logic       p1_down  = 1'b0;
  logic       p2_up    = 1'b0;
  logic       p2_down  = 1'b0;
  logic [4:0] score_p1;
  logic [4:0] score_p2;
  logic [1:0] winner;
  logic       game_over;
  logic       update;
  logic       blink;

  score_controller #(
    .SCORE_W    (5),
    .WIN_SCORE  (11),
    .WIN_MARGIN (2),
    .BLINK_MS   (250)
  ) dut (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .winner    (winner),
    .game_over (game_over),
    .update    (update),
    .blink     (blink)
  );

  always #5 clk_1khz = ~clk_1khz;

  int n_pass  = 0;
  int n_total = 0;
  int upd_count = 0;

  // Model state: pending is 0 none, 1 up, 2 down; m_prio is the player that wins a tie.
  int m_sc[2];
  int m_pend[2];
  int m_prio;
  bit m_won;
  int m_winner;
  bit m_update;
  int m_won_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_sc[0] = 0; m_sc[1] = 0;
    m_pend[0] = 0; m_pend[1] = 0;
    m_prio = 0; m_won = 0; m_winner = 0; m_update = 0; m_won_cyc = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit c, input bit d);
    int g, r, old;
    bit just_won;
    just_won = 0;
    m_update = 0;
    g = -1;
    if (m_pend[0] != 0 && m_pend[1] != 0) g = m_prio;
    else if (m_pend[0] != 0) g = 0;
    else if (m_pend[1] != 0) g = 1;
    if (g >= 0) begin
      r = m_pend[g];
      m_pend[g] = 0;
      m_prio = 1 - g;
      if (!m_won) begin
        old = m_sc[g];
        if (r == 1) m_sc[g] = (old < 31) ? old + 1 : 31;
        else        m_sc[g] = (old > 0) ? old - 1 : 0;
        m_update = (m_sc[g] != old);
        if (m_sc[0] >= 11 && m_sc[0] - m_sc[1] >= 2) begin
          m_won = 1; m_winner = 1; just_won = 1;
        end else if (m_sc[1] >= 11 && m_sc[1] - m_sc[0] >= 2) begin
          m_won = 1; m_winner = 2; just_won = 1;
        end
      end else if (r == 2) begin
        m_sc[0] = 0; m_sc[1] = 0; m_won = 0; m_winner = 0; m_update = 1;
      end
    end
    if (m_won) m_won_cyc = just_won ? 0 : m_won_cyc + 1;
    if (a && !b) m_pend[0] = 1; else if (b && !a) m_pend[0] = 2;
    if (c && !d) m_pend[1] = 1; else if (d && !c) m_pend[1] = 2;
  endtask

  task automatic compare_all();
    chk("score_p1", score_p1, m_sc[0]);
    chk("score_p2", score_p2, m_sc[1]);
    chk("winner", winner, m_winner);
    chk("game_over", game_over, m_won);
    chk("update", update, m_update);
    chk("blink", blink, m_won ? (m_won_cyc / 250) % 2 : 0);
    if (update) upd_count++;
  endtask

  // One clock: present pulses, advance the model at the edge, compare at the falling edge.
  task automatic tick(input bit a, input bit b, input bit c, input bit d);
    p1_up = a; p1_down = b; p2_up = c; p2_down = d;
    @(posedge clk_1khz);
    model_step(a, b, c, d);
    @(negedge clk_1khz);
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_1khz);
    chk("rst_score_p1", score_p1, 0);
    chk("rst_score_p2", score_p2, 0);
    chk("rst_winner", winner, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_update", update, 0);
    chk("rst_blink", blink, 0);
    rst = 1'b0;
    model_reset();
    upd_count = 0;
  endtask

  initial begin
    int toggles;
    bit prev;
    model_reset();
    @(negedge clk_1khz);

    // Three p1 ups with two-edge latency.
    do_reset();
    tick(1, 0, 0, 0);
    chk("t1_lat_first_edge", update, 0);
    idle(1);
    chk("t1_lat_second_edge", update, 1);
    chk("t1_first_score", score_p1, 1);
    tick(1, 0, 0, 0); idle(1);
    tick(1, 0, 0, 0); idle(2);
    chk("t1_score_p1", score_p1, 3);
    chk("t1_score_p2", score_p2, 0);
    chk("t1_updates", upd_count, 3);

    // Simultaneous ups: p1 first, p2 one cycle later.
    do_reset();
    tick(1, 0, 1, 0);
    idle(1);
    chk("t2_p1_first", score_p1, 1);
    chk("t2_p2_waits", score_p2, 0);
    idle(1);
    chk("t2_p2_next", score_p2, 1);
    idle(1);
    chk("t2_updates", upd_count, 2);

    // Cancel and floor.
    upd_count = 0;
    tick(1, 1, 0, 0); idle(2);
    chk("t3_cancel_score", score_p1, 1);
    chk("t3_cancel_updates", upd_count, 0);
    tick(0, 0, 0, 1); idle(1);
    chk("t3_undo", score_p2, 0);
    tick(0, 0, 0, 1); idle(1);
    chk("t3_floor_update", update, 0);
    chk("t3_floor_score", score_p2, 0);

    // Deuce to 10-10, then 11-10 no win, 12-10 win and blink.
    do_reset();
    repeat (10) begin tick(1, 0, 1, 0); idle(2); end
    chk("t4_p1_ten", score_p1, 10);
    chk("t4_p2_ten", score_p2, 10);
    tick(1, 0, 0, 0); idle(2);
    chk("t4_no_win_11_10", game_over, 0);
    tick(1, 0, 0, 0); idle(1);
    chk("t4_game_over", game_over, 1);
    chk("t4_winner", winner, 1);
    toggles = 0;
    prev = blink;
    for (int i = 1; i <= 600; i++) begin
      idle(1);
      if (blink != prev) toggles++;
      prev = blink;
      if (i == 249) chk("t4_blink_before", blink, 0);
      if (i == 250) chk("t4_blink_at_250", blink, 1);
    end
    chk("t4_blink_toggles", toggles, 2);

    // In WON: ups discarded, a down clears the game.
    tick(0, 0, 1, 0); idle(1);
    chk("t5_frozen_p1", score_p1, 12);
    chk("t5_frozen_p2", score_p2, 10);
    tick(0, 1, 0, 0); idle(1);
    chk("t5_clear_p1", score_p1, 0);
    chk("t5_clear_p2", score_p2, 0);
    chk("t5_clear_winner", winner, 0);
    chk("t5_clear_game_over", game_over, 0);
    chk("t5_clear_update", update, 1);

    // Long deuce to 30-30, then saturation at 31.
    repeat (30) begin tick(1, 0, 1, 0); idle(2); end
    tick(1, 0, 0, 0); idle(2);
    chk("sat_31", score_p1, 31);
    tick(1, 0, 0, 0); idle(1);
    chk("sat_hold", score_p1, 31);
    chk("sat_no_update", update, 0);
    chk("sat_no_win", game_over, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 2);
    end

    // Asynchronous reset with a request pending.
    do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    idle(1);
    tick(1, 0, 0, 0);
    chk("t6_before_rst", score_p1, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_score", score_p1, 0);
    chk("t6_async_update", update, 0);
    @(negedge clk_1khz);
    rst = 1'b0;
    model_reset();
    idle(3);
    chk("t6_no_replay", score_p1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
